// File: rtl/ab_dispatch_pkg.sv
// Shared constants and the one-hot dispatcher state encoding for the
// make_A_close_to_B job dispatcher.
package ab_dispatch_pkg;

  localparam int unsigned AB_WIDTH = 12;
  localparam int unsigned AB_DEPTH = 4;
  localparam int unsigned AB_CNT_W = 8;

  typedef enum logic [3:0] {
    DIS_IDLE  = 4'b0001,
    DIS_START = 4'b0010,
    DIS_WAIT  = 4'b0100,
    DIS_ACK   = 4'b1000
  } dis_state_e;

endpackage

// File: rtl/ab_job_dispatcher_if.sv
// Job producer, adjust-unit handshake and result consumer signals of the
// dispatcher; slave is the dispatcher's view, master the environment's.
interface ab_job_dispatcher_if
  import ab_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH = AB_WIDTH,
  parameter int unsigned CNT_W = AB_CNT_W
);

  logic [WIDTH-1:0] JobAin;
  logic [WIDTH-1:0] JobBin;
  logic             JobValid;
  logic             JobReady;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic             Start;
  logic             Ack;
  logic             Qi;
  logic             Qd;
  logic [WIDTH-1:0] A;
  logic             Flag;
  logic [WIDTH-1:0] ResA;
  logic             ResFlag;
  logic [CNT_W-1:0] ResClocks;
  logic             ResValid;
  logic             ResTaken;

  modport slave (
    input  JobAin, JobBin, JobValid, Qi, Qd, A, Flag, ResTaken,
    output JobReady, Ain, Bin, Start, Ack, ResA, ResFlag, ResClocks, ResValid
  );

  modport master (
    output JobAin, JobBin, JobValid, Qi, Qd, A, Flag, ResTaken,
    input  JobReady, Ain, Bin, Start, Ack, ResA, ResFlag, ResClocks, ResValid
  );

endinterface

// File: rtl/ab_job_fifo.sv
// Show-ahead job FIFO; pushes are refused while full regardless of a
// same-cycle pop, so there is no bypass path.
module ab_job_fifo #(
  parameter int unsigned DW    = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ab_job_dispatcher.sv
// Queues (Ain, Bin) jobs and sequences the adjust unit's Start/Ack handshake
// one job at a time, holding each result until the consumer takes it.
module ab_job_dispatcher
  import ab_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH = AB_WIDTH,
  parameter int unsigned DEPTH = AB_DEPTH,
  parameter int unsigned CNT_W = AB_CNT_W
) (
  input logic                Clk,
  input logic                Reset,
  ab_job_dispatcher_if.slave bus
);

  dis_state_e         state_q, state_d;
  logic [WIDTH-1:0]   ain_q, ain_d, bin_q, bin_d;
  logic [WIDTH-1:0]   res_a_q, res_a_d;
  logic               res_flag_q, res_flag_d;
  logic               res_valid_q, res_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   res_clk_q, res_clk_d;
  logic               fifo_full, fifo_empty, pop, capture;
  logic [2*WIDTH-1:0] fifo_dout;

  ab_job_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (bus.JobValid),
    .pop   (pop),
    .din   ({bus.JobAin, bus.JobBin}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign bus.JobReady  = !fifo_full;
  assign bus.Ain       = ain_q;
  assign bus.Bin       = bin_q;
  assign bus.Start     = (state_q == DIS_START);
  assign bus.Ack       = (state_q == DIS_ACK);
  assign bus.ResA      = res_a_q;
  assign bus.ResFlag   = res_flag_q;
  assign bus.ResClocks = res_clk_q;
  assign bus.ResValid  = res_valid_q;

  always_comb begin
    state_d     = state_q;
    ain_d       = ain_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    res_a_d     = res_a_q;
    res_flag_d  = res_flag_q;
    res_clk_d   = res_clk_q;
    res_valid_d = res_valid_q;
    pop         = 1'b0;
    // A held, untaken result blocks capture; the unit then sits in DONE.
    capture     = (state_q == DIS_WAIT) && bus.Qd && (!res_valid_q || bus.ResTaken);

    unique case (state_q)
      DIS_IDLE: begin
        if (!fifo_empty && bus.Qi) begin
          pop     = 1'b1;
          ain_d   = fifo_dout[2*WIDTH-1:WIDTH];
          bin_d   = fifo_dout[WIDTH-1:0];
          cnt_d   = '0;
          state_d = DIS_START;
        end
      end
      DIS_START: state_d = DIS_WAIT;
      DIS_WAIT: begin
        if (!bus.Qd) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (capture) begin
          state_d = DIS_ACK;
        end
      end
      DIS_ACK:  state_d = DIS_IDLE;
      default:  state_d = DIS_IDLE;
    endcase

    if (res_valid_q && bus.ResTaken) res_valid_d = 1'b0;
    if (capture) begin
      res_a_d     = bus.A;
      res_flag_d  = bus.Flag;
      res_clk_d   = cnt_q;
      res_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= DIS_IDLE;
      ain_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      res_a_q     <= '0;
      res_flag_q  <= 1'b0;
      res_clk_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ain_q       <= ain_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      res_a_q     <= res_a_d;
      res_flag_q  <= res_flag_d;
      res_clk_q   <= res_clk_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_ab_job_dispatcher.sv
// Directed bench for ab_job_dispatcher with a behavioural adjust-unit responder.
module tb_ab_job_dispatcher;

  localparam int unsigned W = 12;
  localparam logic [W-1:0] BURST_AIN [5] = '{12'd112, 12'd132, 12'd311, 12'd312, 12'd138};
  localparam logic [W-1:0] BURST_RES [5] = '{12'd49, 12'd59, 12'd69, 12'd79, 12'd89};
  localparam logic [W-1:0] PP_AIN    [5] = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50};

  logic clk = 1'b0;
  logic rst;
  logic hold_ini;
  always #5 clk = ~clk;

  ab_job_dispatcher_if #(.WIDTH(W), .CNT_W(8)) bus ();
  ab_job_dispatcher_if #(.WIDTH(W), .CNT_W(4)) sbus ();

  ab_job_dispatcher #(.WIDTH(W), .DEPTH(4), .CNT_W(8)) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );
  ab_job_dispatcher #(.WIDTH(W), .DEPTH(4), .CNT_W(4)) dut_sat (
    .Clk(clk), .Reset(rst), .bus(sbus)
  );

  // Responder: Qd rises 5 (main) / 20 (saturation) clocks after Start, A=Bin-1.
  logic        r_busy, r_done, s_busy, s_done;
  int unsigned r_cnt, s_cnt;

  assign bus.Qi    = !r_busy && !r_done && !hold_ini;
  assign bus.Qd    = r_done;
  assign bus.Flag  = r_done;
  assign sbus.Qi   = !s_busy && !s_done;
  assign sbus.Qd   = s_done;
  assign sbus.Flag = s_done;

  always @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0; r_done <= 1'b0; r_cnt <= 0; bus.A <= '0;
    end else if (!r_busy && !r_done) begin
      if (bus.Start) begin r_busy <= 1'b1; r_cnt <= 0; end
    end else if (r_busy) begin
      if (r_cnt + 1 == 5) begin r_busy <= 1'b0; r_done <= 1'b1; bus.A <= bus.Bin - 12'd1; end
      else r_cnt <= r_cnt + 1;
    end else if (bus.Ack) begin
      r_done <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      s_busy <= 1'b0; s_done <= 1'b0; s_cnt <= 0; sbus.A <= '0;
    end else if (!s_busy && !s_done) begin
      if (sbus.Start) begin s_busy <= 1'b1; s_cnt <= 0; end
    end else if (s_busy) begin
      if (s_cnt + 1 == 20) begin s_busy <= 1'b0; s_done <= 1'b1; sbus.A <= sbus.Bin - 12'd1; end
      else s_cnt <= s_cnt + 1;
    end else if (sbus.Ack) begin
      s_done <= 1'b0;
    end
  end

  int unsigned start_cnt = 0, ack_cnt = 0, viol_cnt = 0;
  logic [W-1:0] ain_log[$];
  logic [W-1:0] res_log[$];

  always @(negedge clk) begin
    if (bus.Start) begin
      start_cnt++;
      ain_log.push_back(bus.Ain);
      if (!bus.Qi) viol_cnt++;
    end
    if (bus.Ack) ack_cnt++;
    if (bus.ResValid && bus.ResTaken) res_log.push_back(bus.ResA);
  end

  int unsigned n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned n = 0;
    bus.JobAin = a; bus.JobBin = b; bus.JobValid = 1'b1;
    while (!bus.JobReady && n < 50) begin tick(); n++; end
    check("push_timeout", 32'(n >= 50), 0);
    tick();
    bus.JobValid = 1'b0;
  endtask

  task automatic wait_acks(input int unsigned target, input string tag);
    int unsigned n = 0;
    while (ack_cnt < target && n < 300) begin tick(); n++; end
    check(tag, 32'(ack_cnt >= target), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0, a0, l0, r0, n;
    rst = 1'b1; hold_ini = 1'b0;
    bus.JobValid = 1'b0; bus.JobAin = '0; bus.JobBin = '0; bus.ResTaken = 1'b0;
    sbus.JobValid = 1'b0; sbus.JobAin = '0; sbus.JobBin = '0; sbus.ResTaken = 1'b0;
    tick(); tick();
    check("rst_ready", bus.JobReady, 1);
    check("rst_valid", bus.ResValid, 0);
    check("rst_ain", bus.Ain, 0);
    check("rst_start_ack", {bus.Start, bus.Ack}, 0);
    check("rst_clocks", bus.ResClocks, 0);
    rst = 1'b0;

    // Single job
    s0 = start_cnt; a0 = ack_cnt;
    push_job(12'd138, 12'd312);
    wait_acks(a0 + 1, "single_ack_seen");
    tick();
    check("single_starts", start_cnt - s0, 1);
    check("single_acks", ack_cnt - a0, 1);
    check("single_ain", bus.Ain, 138);
    check("single_bin", bus.Bin, 312);
    check("single_resa", bus.ResA, 311);
    check("single_flag", bus.ResFlag, 1);
    check("single_valid", bus.ResValid, 1);
    check("single_clocks", bus.ResClocks, 5);
    bus.ResTaken = 1'b1; tick(); bus.ResTaken = 1'b0;
    check("single_taken", bus.ResValid, 0);

    // Burst fill with no job in flight, then drain in order
    bus.ResTaken = 1'b1; hold_ini = 1'b1;
    s0 = start_cnt; a0 = ack_cnt; l0 = ain_log.size(); r0 = res_log.size();
    push_job(12'd112, 12'd50);
    push_job(12'd132, 12'd60);
    push_job(12'd311, 12'd70);
    push_job(12'd312, 12'd80);
    check("burst_full", bus.JobReady, 0);
    bus.JobAin = 12'd138; bus.JobBin = 12'd90; bus.JobValid = 1'b1; hold_ini = 1'b0;
    tick();
    check("burst_ready_after_pop", bus.JobReady, 1);
    tick();
    bus.JobValid = 1'b0;
    wait_acks(a0 + 5, "burst_acks_seen");
    tick(); tick();
    check("burst_starts", start_cnt - s0, 5);
    check("burst_qi_viol", viol_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("burst_ain%0d", i), 32'(ain_log[l0 + i]), 32'(BURST_AIN[i]));
      check($sformatf("burst_res%0d", i), 32'(res_log[r0 + i]), 32'(BURST_RES[i]));
    end
    bus.ResTaken = 1'b0;

    // Back-pressure
    a0 = ack_cnt;
    push_job(12'd200, 12'd100);
    push_job(12'd300, 12'd150);
    wait_acks(a0 + 1, "bp_first_ack_seen");
    repeat (30) tick();
    check("bp_acks_held", ack_cnt - a0, 1);
    check("bp_qd_held", bus.Qd, 1);
    check("bp_valid", bus.ResValid, 1);
    check("bp_resa1", bus.ResA, 99);
    bus.ResTaken = 1'b1; tick(); bus.ResTaken = 1'b0;
    check("bp_valid_kept", bus.ResValid, 1);
    check("bp_resa2", bus.ResA, 149);
    check("bp_clocks_frozen", bus.ResClocks, 5);
    wait_acks(a0 + 2, "bp_second_ack_seen");
    check("bp_acks", ack_cnt - a0, 2);
    bus.ResTaken = 1'b1; tick(); bus.ResTaken = 1'b0;
    check("bp_cleared", bus.ResValid, 0);

    // Counter saturation on the CNT_W=4 instance
    sbus.JobAin = 12'd5; sbus.JobBin = 12'd7; sbus.JobValid = 1'b1;
    tick();
    sbus.JobValid = 1'b0;
    n = 0;
    while (!sbus.ResValid && n < 200) begin tick(); n++; end
    check("sat_valid", sbus.ResValid, 1);
    check("sat_clocks", sbus.ResClocks, 15);
    check("sat_resa", sbus.ResA, 6);

    // Simultaneous push/pop at occupancy 2
    bus.ResTaken = 1'b1; hold_ini = 1'b1;
    a0 = ack_cnt; l0 = ain_log.size();
    push_job(12'd10, 12'd1);
    push_job(12'd20, 12'd2);
    bus.JobAin = 12'd30; bus.JobBin = 12'd3; bus.JobValid = 1'b1; hold_ini = 1'b0;
    tick();
    bus.JobValid = 1'b0;
    push_job(12'd40, 12'd4);
    hold_ini = 1'b1;
    check("pp_occ3_ready", bus.JobReady, 1);
    push_job(12'd50, 12'd5);
    check("pp_occ4_full", bus.JobReady, 0);
    hold_ini = 1'b0;
    wait_acks(a0 + 5, "pp_acks_seen");
    for (int i = 0; i < 5; i++)
      check($sformatf("pp_ain%0d", i), 32'(ain_log[l0 + i]), 32'(PP_AIN[i]));
    check("pp_qi_viol", viol_cnt, 0);
    tick(); tick();
    bus.ResTaken = 1'b0;

    // Reset mid-job with a held result and queued jobs
    a0 = ack_cnt; hold_ini = 1'b1;
    push_job(12'd1, 12'd11);
    push_job(12'd2, 12'd22);
    push_job(12'd3, 12'd33);
    hold_ini = 1'b0;
    wait_acks(a0 + 1, "mid_first_ack_seen");
    repeat (20) tick();
    check("mid_pre_qd", bus.Qd, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_ain_bin", {bus.Ain, bus.Bin}, 0);
    check("mid_start_ack", {bus.Start, bus.Ack}, 0);
    check("mid_res", {bus.ResValid, bus.ResFlag, bus.ResA}, 0);
    check("mid_clocks", bus.ResClocks, 0);
    check("mid_ready", bus.JobReady, 1);
    s0 = start_cnt; a0 = ack_cnt;
    repeat (30) tick();
    check("mid_no_start", start_cnt - s0, 0);
    check("mid_no_ack", ack_cnt - a0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
